spi_xfer_sequencer: RTL

//   Host-side stage directly upstream of SPI_TOP. Buffers outgoing bytes in a TX FIFO and drives

---
 rtl/spi_seq_pkg.sv | 12 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/spi_xfer_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI transfer sequencer: FSM encodings and byte width.
package spi_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and an occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Next pointer and occupancy values; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty guards the read side.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Burst sequencer in front of SPI_TOP: feeds bytes from a TX FIFO one at a time,
// waits for the SPIF rising edge as completion, and stores each received byte in
// an RX FIFO. dbg_state exposes the FSM state for observation.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_wr_en,
    input  logic [BYTE_W-1:0] tx_wr_data,
    output logic              tx_full,
    output logic [CNT_W-1:0]  tx_count,
    input  logic              rx_rd_en,
    output logic [BYTE_W-1:0] rx_rd_data,
    output logic              rx_empty,
    output logic              rx_overflow,
    output logic [BYTE_W-1:0] spi_data,
    output logic              spi_spe,
    input  logic              spi_spif,
    input  logic [BYTE_W-1:0] spi_rx_byte,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state_q, state_d;
    logic [BYTE_W-1:0] spi_data_q, spi_data_d;
    logic              spi_spe_q, spi_spe_d;
    logic              rx_overflow_q, rx_overflow_d;
    logic              spif_q;
    logic              spif_rise;

    logic              tx_pop;
    logic              tx_empty;
    logic [BYTE_W-1:0] tx_head;
    logic              rx_push;
    logic              rx_full;
    logic [CNT_W-1:0]  rx_count_unused;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (spi_rx_byte),
        .rd_en   (rx_rd_en),
        .rd_data (rx_rd_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count_unused)
    );

    // Only a low-to-high transition of SPIF marks a completed byte, so a level
    // left high from an earlier transfer never completes the current one.
    assign spif_rise = spi_spif & ~spif_q;

    assign spi_data    = spi_data_q;
    assign spi_spe     = spi_spe_q;
    assign rx_overflow = rx_overflow_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

    // Transfer FSM: next state, output register values and FIFO strobes.
    always_comb begin
        state_d       = state_q;
        spi_data_d    = spi_data_q;
        spi_spe_d     = spi_spe_q;
        rx_overflow_d = rx_overflow_q;
        tx_pop        = 1'b0;
        rx_push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                spi_spe_d = 1'b0;
                if (!tx_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                spi_data_d = tx_head;
                tx_pop     = 1'b1;
                state_d    = ST_START;
            end
            ST_START: begin
                spi_spe_d = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (spif_rise) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rx_push = 1'b1;
                // A same-cycle host pop frees a slot, so only flag a true drop.
                if (rx_full && !rx_rd_en) rx_overflow_d = 1'b1;
                if (!tx_empty) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d   = ST_IDLE;
                    spi_spe_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                spi_spe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            spi_data_q    <= '0;
            spi_spe_q     <= 1'b0;
            rx_overflow_q <= 1'b0;
            spif_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            spi_data_q    <= spi_data_d;
            spi_spe_q     <= spi_spe_d;
            rx_overflow_q <= rx_overflow_d;
            spif_q        <= spi_spif;
        end
    end

endmodule
